serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one result bit per clock, LSB first
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a subtraction (sampled only in IDLE)
//   a, b          minuend and subtrahend, captured on the accepted start
//   busy          high in SHIFT and DONE
//   done          one-cycle pulse when diff/borrow are valid
//   diff, borrow  a - b modulo 2^WIDTH and unsigned borrow-out (a < b)
//   ovf           signed overflow of a - b, present only with SERIAL_SUB_OVF_EN defined
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  // one extra count value so that WIDTH itself fits without wrapping
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] ra, rb, rr;
  logic [CW-1:0] cnt;
  logic bin, d, bout, last;
`ifdef SERIAL_SUB_OVF_EN
  // operand signs are shifted out of ra/rb, so keep them for the overflow term
  logic sa, sb;
`endif
  assign d    = ra[0] ^ rb[0] ^ bin;
  assign bout = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bin);
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rr     <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa     <= 1'b0;
      sb     <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          ra    <= a;
          rb    <= b;
          rr    <= '0;
          cnt   <= '0;
          bin   <= 1'b0;
          busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          sa    <= a[WIDTH-1];
          sb    <= b[WIDTH-1];
`endif
        end
        SHIFT: begin
          rr  <= {d, rr[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          bin <= bout;
          cnt <= cnt + 1'b1;
          // the final bit goes straight into the outputs so they change only here
          if (last) begin
            state  <= DONE;
            done   <= 1'b1;
            diff   <= {d, rr[WIDTH-1:1]};
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (sa ^ sb) & (d ^ sa);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, borrow;
  logic [W-1:0] diff;
  logic ovf_obs;
  int tests = 0, fails = 0;
  exp_t q[$];
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d = x - y;
    e.b = x < y;
    e.o = (x[W-1] ^ y[W-1]) & (e.d[W-1] ^ x[W-1]);
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold,
                       input bit scramble);
    exp_t e;
    int n;
    int dones;
    @(negedge clk);
    rst = 1'b0;
    a = x;
    b = y;
    start = 1'b1;
    q.push_back(model(x, y));
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start got %b want 1", busy);
    end
    if (!hold) start = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    n = 0;
    dones = 0;
    while (dones == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) dones++;
    end
    e = q.pop_front();
    tests++;
    if (dones == 0) begin
      fails++;
      $display("FAIL timeout no done within %0d cycles for %h-%h", n, x, y);
      return;
    end
    if (n !== W) begin
      fails++;
      $display("FAIL latency got %0d want %0d", n, W);
    end
    tests++;
    if (diff !== e.d || borrow !== e.b) begin
      fails++;
      $display("FAIL result %h-%h got diff=%h borrow=%b want diff=%h borrow=%b",
               x, y, diff, borrow, e.d, e.b);
    end
`ifdef SERIAL_SUB_OVF_EN
    tests++;
    if (ovf_obs !== e.o) begin
      fails++;
      $display("FAIL ovf %h-%h got %b want %b", x, y, ovf_obs, e.o);
    end
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_done got done=%b busy=%b want 0 0", done, busy);
    end
    if (hold) begin
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1 || busy === 1'b1) dones++;
      end
      tests++;
      if (dones !== 1) begin
        fails++;
        $display("FAIL hold_start_single_done got %0d activity want 1", dones);
      end
      tests++;
      if (diff !== e.d) begin
        fails++;
        $display("FAIL hold_start_diff_held got %h want %h", diff, e.d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0 || ovf_obs !== 1'b0) begin
      fails++;
      $display("FAIL reset got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
               busy, done, diff, borrow, ovf_obs);
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] xs[8] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hAA};
    logic [W-1:0] ys[8] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h55};
    for (int i = 0; i < 8; i++) do_op(xs[i], ys[i], 1'b0, 1'b0);
  endtask

  task automatic test_hold_start();
    do_op(8'hFF, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_input_change();
    do_op(8'h10, 8'h01, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    a = 8'h55;
    b = 8'h22;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs got busy=%b done=%b diff=%h borrow=%b want all 0",
               busy, done, diff, borrow);
    end
    do_op(8'h09, 8'h04, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL stray_done got %0d want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) do_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
